// File: rtl/parking_pkg.sv
// Shared parking-lot definitions: count width, default capacity and the
// exit-gate state encoding used by both the entry-side and exit-side logic.
package parking_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] DEFAULT_CAPACITY = 8'd200;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPENING,
    ST_OPEN,
    ST_CLOSING
  } gate_state_t;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int timer_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter with a zero flag. Load wins over count; the counter
// holds at zero rather than wrapping.
module gate_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, matching real flip-flop behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/exit_gate_controller.sv
// Exit gate FSM and sole owner of the free-space count (parking_capacity).
// Optional OPEN dwell timeout is enabled by defining EXIT_TIMEOUT_EN.
module exit_gate_controller
  import parking_pkg::*;
#(
  parameter logic [CNT_W-1:0] CAPACITY   = DEFAULT_CAPACITY,
  parameter int               GATE_DELAY = 4
`ifdef EXIT_TIMEOUT_EN
  ,
  parameter int               TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exit_req,
  input  logic             exit_sensor,
  input  logic             entry_commit,
  output logic [CNT_W-1:0] parking_capacity,
  output logic             gate_open,
  output logic             exit_busy,
  output logic             exit_done,
  output logic             exit_reject,
  output logic             exit_timeout
);

  localparam int GW = timer_width(GATE_DELAY);
  // OPENING counts GATE_DELAY..0 so the gate rises GATE_DELAY+1 edges after
  // the request; CLOSING counts GATE_DELAY-1..0 for GATE_DELAY cycles.
  localparam logic [GW-1:0] OPEN_LOAD  = GW'(GATE_DELAY);
  localparam logic [GW-1:0] CLOSE_LOAD = GW'(GATE_DELAY - 1);

  gate_state_t   state_q, state_d;
  logic          gt_load, gt_zero;
  logic [GW-1:0] gt_val, gt_count;
  logic          done_d, reject_d, timeout_d;
  logic          inc, dec;

  gate_timer #(.WIDTH(GW)) u_delay_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (gt_load),
    .load_val (gt_val),
    .en       ((state_q == ST_OPENING) || (state_q == ST_CLOSING)),
    .count    (gt_count),
    .zero     (gt_zero)
  );

`ifdef EXIT_TIMEOUT_EN
  localparam int DW = timer_width(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(TIMEOUT_CYCLES - 1);

  logic [DW-1:0] dwell_count;
  logic          dwell_zero;

  // Armed on entry to OPEN; reaching zero marks TIMEOUT_CYCLES idle cycles.
  gate_timer #(.WIDTH(DW)) u_dwell_timer (
    .clk      (clk),
    .reset    (reset),
    .load     ((state_q == ST_OPENING) && gt_zero),
    .load_val (DWELL_LOAD),
    .en       (state_q == ST_OPEN),
    .count    (dwell_count),
    .zero     (dwell_zero)
  );
`endif

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    gt_load   = 1'b0;
    gt_val    = '0;
    done_d    = 1'b0;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exit_req) begin
          if (parking_capacity < CAPACITY) begin
            state_d = ST_OPENING;
            gt_load = 1'b1;
            gt_val  = OPEN_LOAD;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_OPENING: begin
        if (gt_zero) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        if (exit_sensor) begin
          done_d  = 1'b1;
          state_d = ST_CLOSING;
          gt_load = 1'b1;
          gt_val  = CLOSE_LOAD;
        end
`ifdef EXIT_TIMEOUT_EN
        else if (dwell_zero) begin
          timeout_d = 1'b1;
          state_d   = ST_CLOSING;
          gt_load   = 1'b1;
          gt_val    = CLOSE_LOAD;
        end
`endif
      end
      ST_CLOSING: begin
        if (gt_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign inc = (state_q == ST_OPEN) && exit_sensor;
  assign dec = entry_commit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      parking_capacity <= CAPACITY;
      gate_open        <= 1'b0;
      exit_busy        <= 1'b0;
      exit_done        <= 1'b0;
      exit_reject      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_open   <= (state_d == ST_OPEN);
      exit_busy   <= (state_d != ST_IDLE);
      exit_done   <= done_d;
      exit_reject <= reject_d;
      // Simultaneous exit and entry cancel; both ends saturate.
      if (inc && !dec && (parking_capacity < CAPACITY)) begin
        parking_capacity <= parking_capacity + 1'b1;
      end else if (dec && !inc && (parking_capacity != '0)) begin
        parking_capacity <= parking_capacity - 1'b1;
      end
    end
  end

`ifdef EXIT_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) exit_timeout <= 1'b0;
    else       exit_timeout <= timeout_d;
  end
`else
  assign exit_timeout = 1'b0;
  logic unused_ok;
  assign unused_ok = timeout_d;
`endif

endmodule
